alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 30 +++
 rtl/alu_op_decoder.sv | 43 ++++
 rtl/alu_sequencer.sv | 117 +++++++++++
 tb/tb_alu_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU sequencer: opcodes, FSM states, strobe
// positions and per-class strobe hold lengths.
package alu_seq_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_LSH = 3'b011;
  localparam logic [2:0] OP_RSH = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  // Strobe vector bit positions
  localparam int NUM_STB = 4;
  localparam int STB_ADD = 0;
  localparam int STB_SUB = 1;
  localparam int STB_LSH = 2;
  localparam int STB_RSH = 3;

  // Number of cycles the ALU strobe is held for each operation class
  localparam int ARITH_HOLD = 1;
  localparam int SHIFT_HOLD = 3;
  localparam int HOLD_W     = $clog2(SHIFT_HOLD + 1);

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational opcode decoder: one-hot ALU strobe vector, strobe hold
// length and illegal-opcode flag. NOP and illegal opcodes drive no strobe.
module alu_op_decoder
  import alu_seq_pkg::*;
(
  input  logic [2:0]         op,
  output logic [NUM_STB-1:0] strobes,
  output logic [HOLD_W-1:0]  hold,
  output logic               illegal
);

  // Map opcode to strobe, hold length and legality
  always_comb begin
    strobes = '0;
    hold    = '0;
    illegal = 1'b0;
    case (op)
      OP_NOP: begin
        strobes = '0;
      end
      OP_ADD: begin
        strobes[STB_ADD] = 1'b1;
        hold             = HOLD_W'(ARITH_HOLD);
      end
      OP_SUB: begin
        strobes[STB_SUB] = 1'b1;
        hold             = HOLD_W'(ARITH_HOLD);
      end
      OP_LSH: begin
        strobes[STB_LSH] = 1'b1;
        hold             = HOLD_W'(SHIFT_HOLD);
      end
      OP_RSH: begin
        strobes[STB_RSH] = 1'b1;
        hold             = HOLD_W'(SHIFT_HOLD);
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one instruction at a time onto an external registered ALU:
// accepts an instruction, holds the matching strobe for its hold length,
// captures the ALU result one cycle later and offers it with a
// valid/ready handshake. NOP and illegal opcodes skip the ALU entirely.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       instr_op,
  input  logic [WIDTH-1:0] instr_a,
  input  logic [WIDTH-1:0] instr_b,
  output logic             alu_add,
  output logic             alu_sub,
  output logic             alu_lshift,
  output logic             alu_rshift,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_overflow,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_flag,
  output logic             res_err
);

  state_e              state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [NUM_STB-1:0]  strobe_q;
  logic [NUM_STB-1:0]  dec_strobes;
  logic [HOLD_W-1:0]   dec_hold;
  logic                dec_illegal;
  logic                accept;

  alu_op_decoder u_dec (
    .op      (instr_op),
    .strobes (dec_strobes),
    .hold    (dec_hold),
    .illegal (dec_illegal)
  );

  assign instr_ready = (state == ST_IDLE);
  assign accept      = instr_valid && instr_ready;

  assign alu_add    = strobe_q[STB_ADD];
  assign alu_sub    = strobe_q[STB_SUB];
  assign alu_lshift = strobe_q[STB_LSH];
  assign alu_rshift = strobe_q[STB_RSH];

  // Sequencer FSM with registered strobes, operands and result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      strobe_q  <= '0;
      alu_in1   <= '0;
      alu_in2   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_flag  <= 1'b0;
      res_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_in1 <= instr_a;
            alu_in2 <= instr_b;
            if (dec_strobes != '0) begin
              strobe_q <= dec_strobes;
              hold_cnt <= dec_hold;
              state    <= ST_ISSUE;
            end else begin
              // No ALU work: answer immediately with a zero result
              res_valid <= 1'b1;
              res_data  <= '0;
              res_flag  <= 1'b0;
              res_err   <= dec_illegal;
              state     <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          if (hold_cnt <= HOLD_W'(1)) begin
            strobe_q <= '0;
            hold_cnt <= '0;
            state    <= ST_CAPTURE;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        ST_CAPTURE: begin
          // ALU output registered during the last strobe cycle is valid now
          res_valid <= 1'b1;
          res_data  <= alu_out;
          res_flag  <= alu_overflow;
          res_err   <= 1'b0;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural registered ALU.
`timescale 1ns/1ps
module tb_alu_sequencer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         instr_valid = 1'b0;
  logic         instr_ready;
  logic [2:0]   instr_op = 3'b000;
  logic [W-1:0] instr_a = '0;
  logic [W-1:0] instr_b = '0;
  logic         alu_add, alu_sub, alu_lshift, alu_rshift;
  logic [W-1:0] alu_in1, alu_in2;
  logic [W-1:0] alu_out;
  logic         alu_overflow;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W-1:0] res_data;
  logic         res_flag, res_err;
  logic [3:0]   stb;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [3:0] data;
    logic       flag;
    logic       err;
    int         acc;
    int         lat;
    logic [3:0] smask;
    int         scnt;
    logic [3:0] a;
    logic [3:0] b;
  } exp_t;

  exp_t sb[$];

  alu_sequencer #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_op     (instr_op),
    .instr_a      (instr_a),
    .instr_b      (instr_b),
    .alu_add      (alu_add),
    .alu_sub      (alu_sub),
    .alu_lshift   (alu_lshift),
    .alu_rshift   (alu_rshift),
    .alu_in1      (alu_in1),
    .alu_in2      (alu_in2),
    .alu_out      (alu_out),
    .alu_overflow (alu_overflow),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_flag     (res_flag),
    .res_err      (res_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign stb = {alu_rshift, alu_lshift, alu_sub, alu_add};

  // Behavioural registered ALU: carry/borrow or shifted-out bit as flag
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_out      <= '0;
      alu_overflow <= 1'b0;
    end else if (alu_add) begin
      {alu_overflow, alu_out} <= {1'b0, alu_in1} + {1'b0, alu_in2};
    end else if (alu_sub) begin
      alu_out      <= alu_in1 - alu_in2;
      alu_overflow <= (alu_in1 < alu_in2);
    end else if (alu_lshift) begin
      alu_out      <= alu_in1 << 1;
      alu_overflow <= alu_in1[W-1];
    end else if (alu_rshift) begin
      alu_out      <= alu_in1 >> 1;
      alu_overflow <= alu_in1[0];
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: strobe/operand checks every cycle, result checks on handshake
  logic       prev_v = 1'b0;
  logic       prev_hs = 1'b0;
  int         n_stb [4];
  logic [3:0] held_d;
  logic       held_f, held_e;

  always @(negedge clk) begin
    if (!reset) begin
      prev_v  = 1'b0;
      prev_hs = 1'b0;
      for (int i = 0; i < 4; i++) n_stb[i] = 0;
    end else begin
      chk("strobe_onehot0", 32'($onehot0(stb)), 32'd1);
      if (stb != 4'b0000) begin
        if (sb.size() == 0) begin
          chk("strobe_unexpected", 32'(stb), 32'd0);
        end else begin
          chk("alu_in1", 32'(alu_in1), 32'(sb[0].a));
          chk("alu_in2", 32'(alu_in2), 32'(sb[0].b));
        end
        for (int i = 0; i < 4; i++) if (stb[i]) n_stb[i]++;
      end
      if (prev_hs) chk("valid_after_handshake", 32'(res_valid), 32'd0);
      if (res_valid && !prev_v) begin
        if (sb.size() == 0) begin
          chk("result_unexpected", 32'(res_valid), 32'd0);
        end else begin
          chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
          for (int i = 0; i < 4; i++)
            chk("strobe_cycles", 32'(n_stb[i]), 32'(sb[0].smask[i] ? sb[0].scnt : 0));
        end
        held_d = res_data;
        held_f = res_flag;
        held_e = res_err;
      end else if (res_valid && prev_v) begin
        chk("hold_data", 32'(res_data), 32'(held_d));
        chk("hold_flag", 32'(res_flag), 32'(held_f));
        chk("hold_err",  32'(res_err),  32'(held_e));
      end
      if (res_valid && res_ready && sb.size() != 0) begin
        chk("res_data", 32'(res_data), 32'(sb[0].data));
        chk("res_flag", 32'(res_flag), 32'(sb[0].flag));
        chk("res_err",  32'(res_err),  32'(sb[0].err));
        void'(sb.pop_front());
        for (int i = 0; i < 4; i++) n_stb[i] = 0;
      end
      prev_v  = res_valid;
      prev_hs = res_valid && res_ready;
    end
  end

  task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] ed, input logic ef, input logic ee,
                       input int lat, input logic [3:0] sm, input int sc);
    exp_t e;
    int   n;
    instr_valid = 1'b1;
    instr_op    = op;
    instr_a     = a;
    instr_b     = b;
    n = 0;
    while (!instr_ready && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    if (!instr_ready) begin
      chk("accept_timeout", 32'(instr_ready), 32'd1);
      instr_valid = 1'b0;
      return;
    end
    e.data = ed; e.flag = ef; e.err = ee; e.acc = cyc; e.lat = lat;
    e.smask = sm; e.scnt = sc; e.a = a; e.b = b;
    sb.push_back(e);
    @(posedge clk); #2;
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_res_data"},  32'(res_data),  32'd0);
    chk({tag, "_res_flag"},  32'(res_flag),  32'd0);
    chk({tag, "_res_err"},   32'(res_err),   32'd0);
    chk({tag, "_strobes"},   32'(stb),       32'd0);
    chk({tag, "_alu_in1"},   32'(alu_in1),   32'd0);
    chk({tag, "_alu_in2"},   32'(alu_in2),   32'd0);
  endtask

  initial begin
    int n;
    @(posedge clk); #2;
    check_zero_outputs("reset");
    @(posedge clk); #2;
    reset = 1'b1;

    // First instruction offered right after release
    issue(3'b001, 4'd7, 4'd9, 4'h0, 1'b1, 1'b0, 3, 4'b0001, 1);  drain();
    issue(3'b010, 4'd3, 4'd5, 4'hE, 1'b1, 1'b0, 3, 4'b0010, 1);  drain();
    issue(3'b011, 4'b1001, 4'd0, 4'b0010, 1'b1, 1'b0, 5, 4'b0100, 3); drain();
    issue(3'b100, 4'b0110, 4'd0, 4'b0011, 1'b0, 1'b0, 5, 4'b1000, 3); drain();
    issue(3'b111, 4'd5, 4'd6, 4'h0, 1'b0, 1'b1, 1, 4'b0000, 0);  drain();
    issue(3'b000, 4'd5, 4'd5, 4'h0, 1'b0, 1'b0, 1, 4'b0000, 0);  drain();
    issue(3'b101, 4'd1, 4'd2, 4'h0, 1'b0, 1'b1, 1, 4'b0000, 0);  drain();
    issue(3'b001, 4'd2, 4'd3, 4'h5, 1'b0, 1'b0, 3, 4'b0001, 1);  drain();
    issue(3'b010, 4'd9, 4'd4, 4'h5, 1'b0, 1'b0, 3, 4'b0010, 1);  drain();

    // Back-pressure: result held while an ADD is offered and ignored
    res_ready = 1'b0;
    issue(3'b001, 4'd6, 4'd5, 4'hB, 1'b0, 1'b0, 3, 4'b0001, 1);
    n = 0;
    while (!res_valid && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    chk("bp_valid_seen", 32'(res_valid), 32'd1);
    for (int i = 0; i < 6; i++) begin
      instr_valid = 1'b1;
      instr_op    = 3'b001;
      instr_a     = 4'd1;
      instr_b     = 4'd1;
      @(posedge clk); #2;
      chk("bp_instr_ready", 32'(instr_ready), 32'd0);
      chk("bp_res_valid",   32'(res_valid),   32'd1);
    end
    instr_valid = 1'b0;
    res_ready   = 1'b1;
    drain();
    repeat (4) begin
      @(posedge clk); #2;
    end
    chk("bp_idle_ready", 32'(instr_ready), 32'd1);

    // Reset during CAPTURE abandons the ADD
    issue(3'b001, 4'd7, 4'd1, 4'h8, 1'b0, 1'b0, 3, 4'b0001, 1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check_zero_outputs("midreset");
    sb.delete();
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (6) begin
      @(posedge clk); #2;
      chk("post_reset_no_result", 32'(res_valid), 32'd0);
    end
    issue(3'b001, 4'd1, 4'd1, 4'h2, 1'b0, 1'b0, 3, 4'b0001, 1);  drain();
    repeat (3) @(posedge clk);
    #2;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
